seg_decode_monitor: RTL and testbench

- Receive end of the digit→7-segment path: accepts active-low 7-segment codes (HEX-format, bit0 = segment a … bit6 = segment g), decodes them back to a 4-bit digit and checks that successive digits follow the up/down counting sequence.
- Sits behind any block that drives a HEX display. It lets the counter/display chain be self-checked in hardware and in simulation, and reports illegal codes, sequence breaks and a saturating error count.

---
 rtl/seg_decode_monitor_pkg.sv | 24 ++
 rtl/seg7_to_digit.sv | 34 +++
 rtl/seg_decode_monitor.sv | 121 ++++++++++++
 tb/tb_seg_decode_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_decode_monitor_pkg.sv
// Shared constants for the 7-segment receive monitor: active-low segment
// codes (bit6..bit0 = g..a), the illegal-digit marker and the FSM encoding.
package seg_decode_monitor_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational inverse of the HEX digit encoder. Codes that are not one of
// the ten digits, or that decode above DIGIT_MAX, are reported as illegal.
module seg7_to_digit #(
  parameter int DIGIT_MAX = 9
) (
  input  logic [6:0] seg_in,
  output logic       legal,
  output logic [3:0] digit
);
  import seg_decode_monitor_pkg::*;

  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

  logic [3:0] raw;

  always_comb begin
    case (seg_in)
      SEG_0:   raw = 4'd0;
      SEG_1:   raw = 4'd1;
      SEG_2:   raw = 4'd2;
      SEG_3:   raw = 4'd3;
      SEG_4:   raw = 4'd4;
      SEG_5:   raw = 4'd5;
      SEG_6:   raw = 4'd6;
      SEG_7:   raw = 4'd7;
      SEG_8:   raw = 4'd8;
      SEG_9:   raw = 4'd9;
      default: raw = DIGIT_ILLEGAL;
    endcase
    legal = (raw != DIGIT_ILLEGAL) && (raw <= DMAX);
    digit = legal ? raw : DIGIT_ILLEGAL;
  end

endmodule

// File: rtl/seg_decode_monitor.sv
// Decodes active-low 7-segment samples back to digits and checks that they
// follow an up/down wrapping count, flagging illegal codes and sequence breaks.
module seg_decode_monitor #(
  parameter int DIGIT_MAX = 9,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           seg_in,
  input  logic                 seg_valid,
  input  logic                 dir,
  output logic [3:0]           digit_out,
  output logic                 digit_valid,
  output logic                 code_err,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);
  import seg_decode_monitor_pkg::*;

  localparam logic [3:0]           DMAX    = 4'(DIGIT_MAX);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_t               state_reg, state_next;
  logic [3:0]           prev_reg, prev_next;
  logic [3:0]           digit_reg, digit_next;
  logic                 dv_reg, dv_next;
  logic                 ce_reg, ce_next;
  logic                 se_reg, se_next;
  logic [ERR_CNT_W-1:0] cnt_reg, cnt_next;

  logic       legal;
  logic [3:0] digit;
  logic [3:0] expected;

  seg7_to_digit #(.DIGIT_MAX(DIGIT_MAX)) u_dec (
    .seg_in (seg_in),
    .legal  (legal),
    .digit  (digit)
  );

  always_comb begin
    if (dir) expected = (prev_reg == 4'd0) ? DMAX : prev_reg - 4'd1;
    else     expected = (prev_reg == DMAX) ? 4'd0 : prev_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEEK;
      prev_reg  <= 4'd0;
      digit_reg <= 4'd0;
      dv_reg    <= 1'b0;
      ce_reg    <= 1'b0;
      se_reg    <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      digit_reg <= digit_next;
      dv_reg    <= dv_next;
      ce_reg    <= ce_next;
      se_reg    <= se_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    digit_next = digit_reg;
    dv_next    = 1'b0;
    ce_next    = 1'b0;
    se_next    = 1'b0;
    if (seg_valid) begin
      if (!legal) begin
        state_next = SEEK;
        ce_next    = 1'b1;
      end else begin
        dv_next    = 1'b1;
        digit_next = digit;
        // A repeat of prev is the display holding still; it never moves state.
        case (state_reg)
          SEEK: begin
            state_next = TRACK;
            prev_next  = digit;
          end
          TRACK: begin
            if (digit == expected) begin
              state_next = LOCKED;
              prev_next  = digit;
            end else if (digit != prev_reg) begin
              prev_next  = digit;
            end
          end
          LOCKED: begin
            if (digit == expected) begin
              prev_next  = digit;
            end else if (digit != prev_reg) begin
              state_next = TRACK;
              prev_next  = digit;
              se_next    = 1'b1;
            end
          end
          default: begin
            state_next = SEEK;
          end
        endcase
      end
    end
    cnt_next = cnt_reg;
    if ((ce_next || se_next) && (cnt_reg != CNT_MAX)) cnt_next = cnt_reg + 1'b1;
  end

  assign digit_out   = digit_reg;
  assign digit_valid = dv_reg;
  assign code_err    = ce_reg;
  assign seq_err     = se_reg;
  assign locked      = (state_reg == LOCKED);
  assign err_count   = cnt_reg;

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Randomised self-check of seg_decode_monitor (default and DIGIT_MAX=5 /
// ERR_CNT_W=2 builds) against a behavioural model, plus directed literal checks.
module tb_seg_decode_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       seg_valid = 1'b0;
  logic       dir = 1'b0;

  logic [3:0] a_dout, b_dout;
  logic       a_dv, a_ce, a_se, a_lk, b_dv, b_ce, b_se, b_lk;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_decode_monitor #(.DIGIT_MAX(9), .ERR_CNT_W(8)) u9 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid), .dir(dir),
    .digit_out(a_dout), .digit_valid(a_dv), .code_err(a_ce), .seq_err(a_se),
    .locked(a_lk), .err_count(a_cnt)
  );

  seg_decode_monitor #(.DIGIT_MAX(5), .ERR_CNT_W(2)) u5 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid), .dir(dir),
    .digit_out(b_dout), .digit_valid(b_dv), .code_err(b_ce), .seq_err(b_se),
    .locked(b_lk), .err_count(b_cnt)
  );

  // Display patterns written out independently of the RTL package.
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  // Behavioural model, index 0 = u9, index 1 = u5.
  int m_dmax [2] = '{9, 5};
  int m_cmax [2] = '{255, 3};
  bit m_has_ref [2];
  bit m_lock [2];
  int m_prev [2];
  int m_dout [2];
  bit m_dv [2];
  bit m_ce [2];
  bit m_se [2];
  int m_cnt [2];
  bit armed = 1'b0;

  function automatic int decode(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == c) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_has_ref[k] = 0; m_lock[k] = 0; m_prev[k] = 0; m_dout[k] = 0;
        m_dv[k] = 0; m_ce[k] = 0; m_se[k] = 0; m_cnt[k] = 0;
      end else begin
        m_dv[k] = 0; m_ce[k] = 0; m_se[k] = 0;
        if (seg_valid) begin
          int d, ex;
          d = decode(seg_in);
          if (d < 0 || d > m_dmax[k]) begin
            m_ce[k] = 1; m_has_ref[k] = 0; m_lock[k] = 0;
          end else begin
            m_dv[k] = 1; m_dout[k] = d;
            ex = dir ? (m_prev[k] == 0 ? m_dmax[k] : m_prev[k] - 1)
                     : (m_prev[k] == m_dmax[k] ? 0 : m_prev[k] + 1);
            if (!m_has_ref[k]) begin
              m_has_ref[k] = 1; m_prev[k] = d;
            end else if (d == ex) begin
              m_lock[k] = 1; m_prev[k] = d;
            end else if (d != m_prev[k]) begin
              m_se[k] = m_lock[k]; m_lock[k] = 0; m_prev[k] = d;
            end
          end
          if ((m_ce[k] || m_se[k]) && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        end
      end
    end
    if (reset) armed = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("u9.digit_out", a_dout, m_dout[0]);
      check("u9.digit_valid", a_dv, m_dv[0]);
      check("u9.code_err", a_ce, m_ce[0]);
      check("u9.seq_err", a_se, m_se[0]);
      check("u9.locked", a_lk, m_lock[0]);
      check("u9.err_count", a_cnt, m_cnt[0]);
      check("u5.digit_out", b_dout, m_dout[1]);
      check("u5.digit_valid", b_dv, m_dv[1]);
      check("u5.code_err", b_ce, m_ce[1]);
      check("u5.seq_err", b_se, m_se[1]);
      check("u5.locked", b_lk, m_lock[1]);
      check("u5.err_count", b_cnt, m_cnt[1]);
    end
  end

  task automatic drive(input bit r, input bit v, input logic [6:0] c, input bit d);
    reset = r; seg_valid = v; seg_in = c; dir = d;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int digit, input bit d);
    drive(1'b0, 1'b1, seg_tab[digit], d);
  endtask

  initial begin
    int cur;
    int r;
    bit d;
    drive(1'b1, 1'b0, 7'h7F, 1'b0);
    drive(1'b1, 1'b0, 7'h7F, 1'b0);
    check("lit.reset_dout", a_dout, 0);
    check("lit.reset_locked", a_lk, 0);
    check("lit.reset_cnt", a_cnt, 0);

    send(0, 0); send(1, 0);
    check("lit.locked_after_1", a_lk, 1);
    send(2, 0); send(3, 0);
    check("lit.up_dout", a_dout, 3);
    check("lit.up_dv", a_dv, 1);
    check("lit.up_cnt", a_cnt, 0);

    send(7, 0);
    check("lit.break_seq_err", a_se, 1);
    check("lit.break_locked", a_lk, 0);
    check("lit.break_dout", a_dout, 7);
    check("lit.break_cnt", a_cnt, 1);
    check("lit.dmax5_code_err7", b_ce, 1);
    check("lit.dmax5_dout_hold", b_dout, 3);
    send(8, 0);
    check("lit.relock", a_lk, 1);

    drive(1'b0, 1'b1, 7'h7F, 1'b0);
    check("lit.blank_code_err", a_ce, 1);
    check("lit.blank_dv", a_dv, 0);
    check("lit.blank_dout", a_dout, 8);
    check("lit.blank_locked", a_lk, 0);

    send(6, 0);
    check("lit.dmax5_code_err6", b_ce, 1);
    send(5, 0);
    check("lit.track_no_err", a_ce | a_se, 0);
    check("lit.track_unlocked", a_lk, 0);

    send(4, 0); send(5, 0); send(0, 0);
    check("lit.dmax5_wrap_locked", b_lk, 1);
    check("lit.dmax5_wrap_seq", b_se, 0);
    check("lit.dmax5_wrap_dout", b_dout, 0);

    send(1, 1); send(0, 1); send(9, 1);
    check("lit.down_wrap_locked", a_lk, 1);
    check("lit.down_wrap_dout", a_dout, 9);
    check("lit.down_wrap_seq", a_se, 0);
    check("lit.down_cnt", a_cnt, 3);

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 7'h7F, 1'b0);
    check("lit.sat_cnt", b_cnt, 3);

    drive(1'b1, 1'b1, seg_tab[1], 1'b0);
    check("lit.rst_dv", a_dv | b_dv, 0);
    check("lit.rst_dout", a_dout, 0);
    check("lit.rst_cnt", a_cnt, 0);
    check("lit.rst_locked", a_lk | b_lk, 0);

    cur = 0;
    d = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] c;
      r = $urandom_range(99);
      if (r < 55) begin
        cur = d ? (cur == 0 ? 9 : cur - 1) : (cur == 9 ? 0 : cur + 1);
        c = seg_tab[cur];
      end else if (r < 70) begin
        c = seg_tab[cur];
      end else if (r < 82) begin
        cur = $urandom_range(9);
        c = seg_tab[cur];
      end else if (r < 92) begin
        c = 7'($urandom);
      end else begin
        d = ~d;
        c = seg_tab[cur];
      end
      drive($urandom_range(199) == 0, $urandom_range(99) < 75, c, d);
    end
    drive(1'b0, 1'b0, 7'h7F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
